dest_pop_arbiter: RTL and testbench

Drains the two destination FIFOs (D0, D1) of the transmission-layer datapath into a single 6-bit outbound link. It generates D0_pop/D1_pop under credit-based flow control from the downstream receiver, with round-robin fairness between the two FIFOs. It sits between full_logic (empty flags, data outputs, error flags) and the link interface. It also owns the link-side INIT/IDLE/ACTIVE/ERROR sequencing.

---
 rtl/dest_pop_arbiter.sv | 133 +++++++++++++
 tb/tb_dest_pop_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dest_pop_arbiter.sv
// Drains FIFOs D0/D1 onto one link, round-robin (fixed D0 priority when STRICT_PRIO_D0_EN is defined).
// Latency: pop registered at edge N, link word valid after edge N+2; one word per cycle when streaming.
// Backpressure: no pops while credits are zero; each credit_return re-enables one pop.
module dest_pop_arbiter #(
  parameter int DATA_WIDTH   = 6,
  parameter int CREDIT_WIDTH = 4,
  parameter int MAX_CREDITS  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic                    empty_fifo_D0,
  input  logic                    empty_fifo_D1,
  input  logic [DATA_WIDTH-1:0]   data_out_D0,
  input  logic [DATA_WIDTH-1:0]   data_out_D1,
  input  logic                    error_D0,
  input  logic                    error_D1,
  input  logic                    credit_return,
  output logic                    D0_pop,
  output logic                    D1_pop,
  output logic [DATA_WIDTH-1:0]   link_data,
  output logic                    link_valid,
  output logic                    link_src,
  output logic [CREDIT_WIDTH-1:0] credits_avail,
  output logic [1:0]              arb_state,
  output logic                    arb_error
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = CREDIT_WIDTH'(MAX_CREDITS);
  localparam logic [CREDIT_WIDTH-1:0] CRED_ONE = CREDIT_WIDTH'(1);

  state_t state;
  logic   rd_vld;
  logic   rd_src;
`ifdef STRICT_PRIO_D0_EN
`else
  logic   last_grant;
`endif

  logic any_ne;
  logic pick_d1;
  logic pop_now;
  logic ovf;
  logic err_evt;

  assign arb_state = state;

  always_comb begin
    any_ne = !empty_fifo_D0 || !empty_fifo_D1;
`ifdef STRICT_PRIO_D0_EN
    pick_d1 = empty_fifo_D0;
`else
    pick_d1 = (!empty_fifo_D0 && !empty_fifo_D1) ? ~last_grant : empty_fifo_D0;
`endif
    // A FIFO error or re-init suppresses the pop so only already-popped words stay in flight.
    pop_now = ((state == ST_IDLE) || (state == ST_ACTIVE)) && (credits_avail != '0) &&
              any_ne && !init && !error_D0 && !error_D1;
    ovf     = credit_return && !pop_now && (credits_avail == CRED_MAX);
    err_evt = error_D0 || error_D1 || ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_INIT;
      credits_avail <= CRED_MAX;
      D0_pop        <= 1'b0;
      D1_pop        <= 1'b0;
      rd_vld        <= 1'b0;
      rd_src        <= 1'b0;
      link_valid    <= 1'b0;
      link_data     <= '0;
      link_src      <= 1'b0;
      arb_error     <= 1'b0;
`ifdef STRICT_PRIO_D0_EN
`else
      last_grant    <= 1'b1;
`endif
    end else if (init) begin
      state         <= ST_INIT;
      credits_avail <= CRED_MAX;
      D0_pop        <= 1'b0;
      D1_pop        <= 1'b0;
      rd_vld        <= 1'b0;
      link_valid    <= 1'b0;
      arb_error     <= 1'b0;
`ifdef STRICT_PRIO_D0_EN
`else
      last_grant    <= 1'b1;
`endif
    end else begin
      D0_pop <= pop_now && !pick_d1;
      D1_pop <= pop_now && pick_d1;
`ifdef STRICT_PRIO_D0_EN
`else
      if (pop_now) last_grant <= pick_d1;
`endif
      case ({pop_now, credit_return})
        2'b10:   credits_avail <= credits_avail - CRED_ONE;
        2'b01:   if (credits_avail != CRED_MAX) credits_avail <= credits_avail + CRED_ONE;
        default: credits_avail <= credits_avail;
      endcase

      // pop reg -> FIFO read cycle -> output reg
      rd_vld     <= D0_pop || D1_pop;
      rd_src     <= D1_pop;
      link_valid <= rd_vld;
      if (rd_vld) begin
        link_data <= rd_src ? data_out_D1 : data_out_D0;
        link_src  <= rd_src;
      end

      if (err_evt) begin
        state     <= ST_ERROR;
        arb_error <= 1'b1;
      end else begin
        case (state)
          ST_INIT:   state <= ST_IDLE;
          ST_IDLE:   if (any_ne && credits_avail != '0) state <= ST_ACTIVE;
          ST_ACTIVE: if (!any_ne || credits_avail == '0) state <= ST_IDLE;
          default:   state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dest_pop_arbiter.sv
// Bench for dest_pop_arbiter: behavioural FIFOs plus a queue-based delivery model of the link.
module tb_dest_pop_arbiter;
  localparam int DW   = 6;
  localparam int CW   = 4;
  localparam int MAXC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, init = 1'b0;
  logic          empty_fifo_D0 = 1'b1, empty_fifo_D1 = 1'b1;
  logic [DW-1:0] data_out_D0 = '0, data_out_D1 = '0;
  logic          error_D0 = 1'b0, error_D1 = 1'b0, credit_return = 1'b0;
  logic          D0_pop, D1_pop, link_valid, link_src, arb_error;
  logic [DW-1:0] link_data;
  logic [CW-1:0] credits_avail;
  logic [1:0]    arb_state;

  dest_pop_arbiter #(.DATA_WIDTH(DW), .CREDIT_WIDTH(CW), .MAX_CREDITS(MAXC)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
    .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
    .error_D0(error_D0), .error_D1(error_D1), .credit_return(credit_return),
    .D0_pop(D0_pop), .D1_pop(D1_pop), .link_data(link_data), .link_valid(link_valid),
    .link_src(link_src), .credits_avail(credits_avail), .arb_state(arb_state),
    .arb_error(arb_error)
  );

  int vectors = 0;
  int miscompares = 0;

  // FIFO environment
  logic [DW-1:0] q0[$], q1[$];
  logic [DW-1:0] pend0, pend1;
  bit            pend0_vld = 0, pend1_vld = 0;
  int            pops_seen = 0;
  int            pop_log[$];

  // reference model: words scheduled for delivery on the link
  typedef struct {
    int            due;
    logic [DW-1:0] dat;
    logic          src;
  } flight_t;
  flight_t       sched[$];
  int            cyc = 0, m_state = 0, m_cred = MAXC, m_last = 1;
  bit            m_err = 0, armed = 0;
  bit            e_pop0 = 0, e_pop1 = 0, e_lvld = 0, e_lsrc = 0;
  logic [DW-1:0] e_ldat = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int      pre_cred;
    bit      ne0, ne1, pick1, pop, ovf;
    flight_t fl;
    cyc++;
    e_pop0 = 0;
    e_pop1 = 0;
    if (reset) begin
      m_state = 0; m_cred = MAXC; m_last = 1; m_err = 0;
      sched.delete(); e_ldat = '0; e_lsrc = 0; armed = 1;
    end else if (init) begin
      m_state = 0; m_cred = MAXC; m_last = 1; m_err = 0;
      sched.delete();
    end else begin
      pre_cred = m_cred;
      ne0 = q0.size() > 0;
      ne1 = q1.size() > 0;
      pop = (m_state == 1 || m_state == 2) && m_cred > 0 && (ne0 || ne1) && !error_D0 && !error_D1;
`ifdef STRICT_PRIO_D0_EN
      pick1 = !ne0;
`else
      pick1 = (ne0 && ne1) ? (m_last == 0) : !ne0;
`endif
      ovf = 0;
      if (pop) begin
        fl.due = cyc + 2;
        fl.dat = pick1 ? q1[0] : q0[0];
        fl.src = pick1;
        sched.push_back(fl);
        m_last = pick1 ? 1 : 0;
        m_cred--;
        e_pop0 = !pick1;
        e_pop1 = pick1;
      end
      if (credit_return) begin
        if (m_cred == MAXC) ovf = 1;
        else m_cred++;
      end
      if (error_D0 || error_D1 || ovf) begin
        m_state = 3;
        m_err = 1;
      end else begin
        case (m_state)
          0: m_state = 1;
          1: if ((ne0 || ne1) && pre_cred > 0) m_state = 2;
          2: if (!(ne0 || ne1) || pre_cred == 0) m_state = 1;
          default: ;
        endcase
      end
    end
    e_lvld = 0;
    if (sched.size() > 0 && sched[0].due == cyc) begin
      e_lvld = 1;
      e_ldat = sched[0].dat;
      e_lsrc = sched[0].src;
      void'(sched.pop_front());
    end
  endtask

  // FIFO reaction to the pops now visible: empty updates at once, data the next cycle
  task automatic env_update();
    data_out_D0 = pend0_vld ? pend0 : DW'($urandom);
    data_out_D1 = pend1_vld ? pend1 : DW'($urandom);
    pend0_vld = 0;
    pend1_vld = 0;
    if (D0_pop === 1'b1) begin
      chk("d0_nonempty_at_pop", q0.size() > 0, 1);
      if (q0.size() > 0) begin pend0 = q0.pop_front(); pend0_vld = 1; end
      pops_seen++;
      pop_log.push_back(0);
    end
    if (D1_pop === 1'b1) begin
      chk("d1_nonempty_at_pop", q1.size() > 0, 1);
      if (q1.size() > 0) begin pend1 = q1.pop_front(); pend1_vld = 1; end
      pops_seen++;
      pop_log.push_back(1);
    end
    empty_fifo_D0 = (q0.size() == 0);
    empty_fifo_D1 = (q1.size() == 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    env_update();
    if (armed) begin
      chk("D0_pop", D0_pop, e_pop0);
      chk("D1_pop", D1_pop, e_pop1);
      chk("credits_avail", credits_avail, m_cred);
      chk("arb_state", arb_state, m_state);
      chk("arb_error", arb_error, m_err);
      chk("link_valid", link_valid, e_lvld);
      chk("link_data", link_data, e_ldat);
      chk("link_src", link_src, e_lsrc);
    end
  endtask

  task automatic push(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) q0.push_back(DW'($urandom));
      else q1.push_back(DW'($urandom));
    end
    empty_fifo_D0 = (q0.size() == 0);
    empty_fifo_D1 = (q1.size() == 0);
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    pend0_vld = 0;
    pend1_vld = 0;
    empty_fifo_D0 = 1'b1;
    empty_fifo_D1 = 1'b1;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    pops_seen = 0;
    pop_log.delete();
  endtask

  initial begin
    int n;
    // idle after reset
    do_reset();
    repeat (4) cycle();
    chk("t1_state_idle", arb_state, 1);
    chk("t1_credits", credits_avail, MAXC);
    chk("t1_no_pops", pops_seen, 0);

    // three words each, no returns: alternating pops, 2 credits left
    push(0, 3);
    push(1, 3);
    repeat (12) cycle();
    chk("t2_pops", pops_seen, 6);
    chk("t2_credits", credits_avail, 2);

    // credit exhaustion, then one returned credit
    do_reset();
    push(0, 10);
    repeat (15) cycle();
    chk("t3_pops", pops_seen, 8);
    chk("t3_credits", credits_avail, 0);
    chk("t3_state_idle", arb_state, 1);
    credit_return = 1'b1;
    cycle();
    credit_return = 1'b0;
    repeat (5) cycle();
    chk("t3_pops_after_return", pops_seen, 9);

    // credit overflow -> ERROR until init
    do_reset();
    repeat (2) cycle();
    credit_return = 1'b1;
    cycle();
    credit_return = 1'b0;
    chk("t4_state_err", arb_state, 3);
    chk("t4_err_flag", arb_error, 1);
    push(0, 2);
    repeat (4) cycle();
    chk("t4_no_pops_in_error", pops_seen, 0);
    init = 1'b1;
    cycle();
    init = 1'b0;
    chk("t4_state_init", arb_state, 0);
    chk("t4_credits_reload", credits_avail, MAXC);
    chk("t4_err_cleared", arb_error, 0);
    cycle();
    chk("t4_state_idle", arb_state, 1);
    repeat (5) cycle();
    chk("t4_pops_after_init", pops_seen, 2);

    // FIFO error mid-stream: in-flight words still delivered
    do_reset();
    push(0, 6);
    push(1, 6);
    repeat (5) cycle();
    error_D1 = 1'b1;
    cycle();
    error_D1 = 1'b0;
    chk("t5_state_err", arb_state, 3);
    n = link_valid ? 1 : 0;
    repeat (5) begin
      cycle();
      n += link_valid ? 1 : 0;
    end
    chk("t5_inflight_words", n, 2);

    // pop order with two words in each FIFO
    do_reset();
    push(0, 2);
    push(1, 2);
    repeat (10) cycle();
    chk("t6_pop_count", pop_log.size(), 4);
    if (pop_log.size() == 4) begin
`ifdef STRICT_PRIO_D0_EN
      chk("t6_order0", pop_log[0], 0);
      chk("t6_order1", pop_log[1], 0);
      chk("t6_order2", pop_log[2], 1);
      chk("t6_order3", pop_log[3], 1);
`else
      chk("t6_order0", pop_log[0], 0);
      chk("t6_order1", pop_log[1], 1);
      chk("t6_order2", pop_log[2], 0);
      chk("t6_order3", pop_log[3], 1);
`endif
    end

    // randomized traffic against the model
    do_reset();
    repeat (600) begin
      if ($urandom_range(99) < 35 && q0.size() < 12) push(0, 1);
      if ($urandom_range(99) < 35 && q1.size() < 12) push(1, 1);
      credit_return = (m_cred < MAXC) ? ($urandom_range(99) < 40) : ($urandom_range(99) < 3);
      error_D0 = ($urandom_range(249) == 0);
      error_D1 = ($urandom_range(249) == 0);
      init = (m_state == 3) ? ($urandom_range(9) == 0) : ($urandom_range(149) == 0);
      cycle();
    end
    credit_return = 1'b0;
    error_D0 = 1'b0;
    error_D1 = 1'b0;
    init = 1'b0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
